// File: rtl/axil_reg_slave.sv
// ---------------------------------------------------------------------------
// axil_reg_slave
//   AXI4-Lite slave holding NUM_REGS 32-bit read/write control registers.
//   The registers are exposed as a flat bus (reg_q). reg_wr_pulse[i] goes
//   high for one cycle after register i is written.
//   The write channel and the read channel run independently. Each channel
//   has at most one response outstanding.
//
//   Build option:
//     AXIL_SLV_RESP_ERR_EN  defined   : out-of-range accesses answer SLVERR
//                           undefined : out-of-range accesses answer OKAY
//     Out-of-range writes are always dropped. Out-of-range reads always
//     return 0.
//
//   Ports:
//     clk, rst            clock; synchronous active-high reset
//     S_AXI_AW*/W*/B*     AXI4-Lite write address, data and response
//     S_AXI_AR*/R*        AXI4-Lite read address and data
//     reg_q               register i at [32i+31:32i]
//     reg_wr_pulse        bit i pulses the cycle after register i is written
// ---------------------------------------------------------------------------
module axil_reg_slave #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [31:0]              S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int          IDX_W     = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef AXIL_SLV_RESP_ERR_EN
  localparam logic [1:0]  RESP_OOR  = 2'b10;
`else
  localparam logic [1:0]  RESP_OOR  = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP}           r_state_t;

  // Register storage and datapath
  logic [31:0]      regs [NUM_REGS];
  logic [IDX_W-1:0] aw_idx, ar_idx_d, aw_idx_d;
  logic             aw_ok, aw_in, ar_in;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic [32:0]      aw_diff, ar_diff;

  // Write channel state
  w_state_t w_state, w_state_n;
  logic     aw_held, aw_held_n, w_held, w_held_n;
  logic     awready_q, wready_q, commit;
  logic     aw_fire, w_fire;

  // Read channel state
  r_state_t r_state, r_state_n;
  logic     arready_q, ar_fire;

  // Decode. The 33-bit difference makes its top bit a borrow flag, so an
  // address below BASE_ADDR can never wrap around into the register window.
  assign aw_diff  = {1'b0, S_AXI_AWADDR} - {1'b0, BASE_ADDR};
  assign ar_diff  = {1'b0, S_AXI_ARADDR} - {1'b0, BASE_ADDR};
  assign aw_in    = !aw_diff[32] && (aw_diff[31:0] < 32'(NUM_REGS * 4));
  assign ar_in    = !ar_diff[32] && (ar_diff[31:0] < 32'(NUM_REGS * 4));
  assign aw_idx_d = aw_diff[IDX_W+1:2];
  assign ar_idx_d = ar_diff[IDX_W+1:2];

  assign aw_fire = S_AXI_AWVALID && awready_q;
  assign w_fire  = S_AXI_WVALID  && wready_q;
  assign ar_fire = S_AXI_ARVALID && arready_q;

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = (r_state == R_RESP);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[32*i +: 32] = regs[i];
  end

  // Write FSM next state. AW and W are captured in any order. The commit
  // happens one cycle after both have been captured.
  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    commit    = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (aw_fire) aw_held_n = 1'b1;
        if (w_fire)  w_held_n  = 1'b1;
        if (aw_held_n && w_held_n) w_state_n = W_COMMIT;
      end
      W_COMMIT: begin
        commit    = 1'b1;
        aw_held_n = 1'b0;
        w_held_n  = 1'b0;
        w_state_n = W_RESP;
      end
      W_RESP:  if (S_AXI_BREADY) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  // NOTE: every sequential process uses non-blocking assignments, so all
  // state updates on an edge see the pre-edge values. This is also what
  // makes a read that coincides with a commit return the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state      <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      aw_ok        <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BRESP  <= RESP_OKAY;
      reg_wr_pulse <= '0;
      // NOTE: the register bank is deliberately reset. Downstream logic
      // sees these values as control settings, so a defined value of 0 at
      // reset is part of the contract. This is not an inferred RAM.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      w_state      <= w_state_n;
      aw_held      <= aw_held_n;
      w_held       <= w_held_n;
      awready_q    <= !aw_held_n && (w_state_n != W_RESP);
      wready_q     <= !w_held_n  && (w_state_n != W_RESP);
      reg_wr_pulse <= '0;
      if (aw_fire) begin
        aw_ok  <= aw_in;
        aw_idx <= aw_idx_d;
      end
      if (w_fire) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        S_AXI_BRESP <= aw_ok ? RESP_OKAY : RESP_OOR;
        if (aw_ok) begin
          reg_wr_pulse[aw_idx] <= 1'b1;
          for (int b = 0; b < 4; b++)
            if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Read FSM next state
  always_comb begin
    r_state_n = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_fire)      r_state_n = R_RESP;
      R_RESP:  if (S_AXI_RREADY) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      arready_q   <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      r_state   <= r_state_n;
      arready_q <= (r_state_n == R_IDLE);
      if (ar_fire) begin
        S_AXI_RDATA <= ar_in ? regs[ar_idx_d] : 32'h0;
        S_AXI_RRESP <= ar_in ? RESP_OKAY : RESP_OOR;
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_slave
//   Directed testbench for axil_reg_slave (NUM_REGS=16, BASE_ADDR=0).
//   Inputs are driven and outputs are sampled on the falling clock edge.
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_axil_reg_slave;

  localparam int NUM_REGS = 16;
`ifdef AXIL_SLV_RESP_ERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [31:0]            awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]             wstrb = '0;
  logic                   awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic                   arvalid = 1'b0, rready = 1'b0;
  logic                   awready, wready, bvalid, arready, rvalid;
  logic [1:0]             bresp, rresp;
  logic [31:0]            rdata;
  logic [32*NUM_REGS-1:0] reg_q;
  logic [NUM_REGS-1:0]    reg_wr_pulse;

  int n_checks = 0;
  int n_errors = 0;

  axil_reg_slave #(.NUM_REGS(NUM_REGS), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return reg_q[32*i +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full write with BREADY high. Returns the response and the pulse vector
  // seen while BVALID is high.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [NUM_REGS-1:0] pulse);
    logic aw_f, w_f;
    int   n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      step();
      if (aw_f) awvalid = 1'b0;
      if (w_f)  wvalid  = 1'b0;
      n++;
    end
    check("wr_accept", {30'b0, awvalid, wvalid}, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      step();
      n++;
    end
    check("wr_bvalid", {31'b0, bvalid}, 32'h1);
    resp  = bresp;
    pulse = reg_wr_pulse;
    step();
    check("wr_b_done", {31'b0, bvalid}, 32'h0);
    check("wr_pulse_1cyc", {16'b0, reg_wr_pulse}, 32'h0);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic f;
    int   n;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (arvalid && n < 20) begin
      f = arready;
      step();
      if (f) arvalid = 1'b0;
      n++;
    end
    check("rd_accept", {31'b0, arvalid}, 32'h0);
    arvalid = 1'b0;
    check("rd_rvalid", {31'b0, rvalid}, 32'h1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    step();
    check("rd_r_done", {31'b0, rvalid}, 32'h0);
    rready = 1'b0;
  endtask

  logic [1:0]             resp;
  logic [31:0]            data;
  logic [NUM_REGS-1:0]    pulse;
  logic [32*NUM_REGS-1:0] snap;

  initial begin
    // Reset: hold three cycles, then release.
    @(negedge clk);
    step(); step();
    check("rst_awready_low", {31'b0, awready}, 32'h0);
    rst = 1'b0;
    step();
    check("rst_awready", {31'b0, awready}, 32'h1);
    check("rst_wready", {31'b0, wready}, 32'h1);
    check("rst_arready", {31'b0, arready}, 32'h1);
    check("rst_valids", {30'b0, bvalid, rvalid}, 32'h0);
    for (int i = 0; i < NUM_REGS; i++) check("rst_reg_zero", reg_at(i), 32'h0);

    // AW and W in the same cycle, full strobe, to reg 2.
    awaddr = 32'h8; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_no_b_yet", {31'b0, bvalid}, 32'h0);
    check("wr_awready_busy", {31'b0, awready}, 32'h0);
    step();
    check("wr_bvalid_lat", {31'b0, bvalid}, 32'h1);
    check("wr_bresp", {30'b0, bresp}, 32'h0);
    check("wr_pulse2", {16'b0, reg_wr_pulse}, 32'h0004);
    check("wr_reg2", reg_at(2), 32'hDEAD_BEEF);
    step();
    check("wr_b_dropped", {31'b0, bvalid}, 32'h0);
    check("wr_pulse_gone", {16'b0, reg_wr_pulse}, 32'h0);
    check("wr_ready_back", {30'b0, awready, wready}, 32'h3);
    bready = 1'b0;
    axi_read(32'h8, data, resp);
    check("rd_reg2", data, 32'hDEAD_BEEF);
    check("rd_reg2_resp", {30'b0, resp}, 32'h0);

    // Partial strobe: W arrives three cycles before AW.
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
    step();
    wvalid = 1'b0;
    check("w_only_wready", {31'b0, wready}, 32'h0);
    check("w_only_awready", {31'b0, awready}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("w_only_no_b", {31'b0, bvalid}, 32'h0);
    end
    awaddr = 32'h8; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check("aw_late_no_b", {31'b0, bvalid}, 32'h0);
    step();
    check("aw_late_bvalid", {31'b0, bvalid}, 32'h1);
    check("partial_reg2", reg_at(2), 32'hDE22_BE44);
    step();
    bready = 1'b0;
    axi_read(32'h0B, data, resp);
    check("rd_lowbits_ign", data, 32'hDE22_BE44);

    // Backpressure on B, with a second write waiting.
    awaddr = 32'h14; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    check("bp_bvalid", {31'b0, bvalid}, 32'h1);
    awaddr = 32'h18; wdata = 32'hCAFE_F00D; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_bvalid_hold", {31'b0, bvalid}, 32'h1);
      check("bp_bresp_hold", {30'b0, bresp}, 32'h0);
      check("bp_readys_low", {30'b0, awready, wready}, 32'h0);
      check("bp_reg6_untouched", reg_at(6), 32'h0);
    end
    bready = 1'b1;
    step();
    check("bp_b_done", {31'b0, bvalid}, 32'h0);
    check("bp_readys_back", {30'b0, awready, wready}, 32'h3);
    axi_write(32'h18, 32'hCAFE_F00D, 4'hF, resp, pulse);
    check("bp_reg5", reg_at(5), 32'h1234_5678);
    check("bp_reg6", reg_at(6), 32'hCAFE_F00D);
    check("bp_pulse6", {16'b0, pulse}, 32'h0040);

    // A write with WSTRB=0 changes nothing but is still answered and pulsed.
    axi_write(32'h14, 32'hFFFF_FFFF, 4'h0, resp, pulse);
    check("strb0_resp", {30'b0, resp}, 32'h0);
    check("strb0_pulse", {16'b0, pulse}, 32'h0020);
    check("strb0_reg5", reg_at(5), 32'h1234_5678);

    // Last register in range.
    axi_write(32'h3C, 32'hA5A5_A5A5, 4'hF, resp, pulse);
    check("top_pulse15", {16'b0, pulse}, 32'h8000);
    axi_read(32'h3C, data, resp);
    check("top_rd15", data, 32'hA5A5_A5A5);

    // Out of range.
    snap = reg_q;
    axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, resp, pulse);
    check("oor_bresp", {30'b0, resp}, {30'b0, EXP_OOR});
    check("oor_no_pulse", {16'b0, pulse}, 32'h0);
    for (int i = 0; i < NUM_REGS; i++) check("oor_reg_same", reg_at(i), snap[32*i +: 32]);
    axi_read(32'h40, data, resp);
    check("oor_rdata", data, 32'h0);
    check("oor_rresp", {30'b0, resp}, {30'b0, EXP_OOR});
    axi_read(32'hFFFF_FFFC, data, resp);
    check("oor_hi_rdata", data, 32'h0);

    // Read and commit of reg 3 on the same edge.
    axi_write(32'hC, 32'h5, 4'hF, resp, pulse);
    awaddr = 32'hC; wdata = 32'h9; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'hC; arvalid = 1'b1;
    check("cc_arready", {31'b0, arready}, 32'h1);
    step();
    arvalid = 1'b0;
    check("cc_rvalid", {31'b0, rvalid}, 32'h1);
    check("cc_old_value", rdata, 32'h5);
    check("cc_bvalid", {31'b0, bvalid}, 32'h1);
    check("cc_reg3_new", reg_at(3), 32'h9);
    rready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    axi_read(32'hC, data, resp);
    check("cc_new_value", data, 32'h9);

    // Reset while a read response is pending.
    araddr = 32'h8; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    check("rr_rvalid", {31'b0, rvalid}, 32'h1);
    rst = 1'b1;
    step();
    check("rr_rvalid_cleared", {31'b0, rvalid}, 32'h0);
    check("rr_arready_low", {31'b0, arready}, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("rr_arready_back", {31'b0, arready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rr_no_response", {30'b0, rvalid, bvalid}, 32'h0);
    end
    for (int i = 0; i < NUM_REGS; i++) check("rr_reg_zero", reg_at(i), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
